// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection; 1-cycle latency, Hold freezes, Flush/Stall insert a bubble.
// Optional bubble counter on StallCount is built only when ID_EX_STALL_CNT_EN is defined.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ID_Rs1,
    input  logic [4:0]      ID_Rs2,
    input  logic [4:0]      ID_Rd,
    input  logic            ID_RegWrite,
    input  logic            ID_MemRead,
    input  logic            ID_MemWrite,
    input  logic            ID_MemtoReg,
    input  logic            ID_ALUSrc,
    input  logic            ID_Branch,
    input  logic [1:0]      ID_ALUOp,
    input  logic [3:0]      ID_Funct,
    input  logic [XLEN-1:0] ID_RD1,
    input  logic [XLEN-1:0] ID_RD2,
    input  logic [XLEN-1:0] ID_Imm,
    input  logic [XLEN-1:0] ID_PC,
    input  logic            Flush,
    input  logic            Hold,
    output logic [4:0]      EX_Rs1,
    output logic [4:0]      EX_Rs2,
    output logic [4:0]      EX_Rd,
    output logic            EX_RegWrite,
    output logic            EX_MemRead,
    output logic            EX_MemWrite,
    output logic            EX_MemtoReg,
    output logic            EX_ALUSrc,
    output logic            EX_Branch,
    output logic [1:0]      EX_ALUOp,
    output logic [3:0]      EX_Funct,
    output logic [XLEN-1:0] EX_RD1,
    output logic [XLEN-1:0] EX_RD2,
    output logic [XLEN-1:0] EX_Imm,
    output logic [XLEN-1:0] EX_PC,
    output logic            EX_Valid,
    output logic            Stall,
    output logic [31:0]     StallCount
);

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            alu_src;
        logic            branch;
        logic [1:0]      alu_op;
        logic [3:0]      funct;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            valid;
    } ex_t;

    ex_t ex_q, ex_d;

    // Flush and Hold mask the hazard so the upstream stages are never frozen by a dead instruction.
    assign Stall = ex_q.mem_read && (ex_q.rd != 5'd0) &&
                   ((ex_q.rd == ID_Rs1) || (ex_q.rd == ID_Rs2)) && !Flush && !Hold;

    always_comb begin
        ex_d = ex_q;
        if (Hold) begin
            ex_d = ex_q;
        end else if (Flush || Stall) begin
            ex_d = '0;
        end else begin
            ex_d.rs1        = ID_Rs1;
            ex_d.rs2        = ID_Rs2;
            ex_d.rd         = ID_Rd;
            ex_d.reg_write  = ID_RegWrite;
            ex_d.mem_read   = ID_MemRead;
            ex_d.mem_write  = ID_MemWrite;
            ex_d.mem_to_reg = ID_MemtoReg;
            ex_d.alu_src    = ID_ALUSrc;
            ex_d.branch     = ID_Branch;
            ex_d.alu_op     = ID_ALUOp;
            ex_d.funct      = ID_Funct;
            ex_d.rd1        = ID_RD1;
            ex_d.rd2        = ID_RD2;
            ex_d.imm        = ID_Imm;
            ex_d.pc         = ID_PC;
            ex_d.valid      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign EX_Rs1      = ex_q.rs1;
    assign EX_Rs2      = ex_q.rs2;
    assign EX_Rd       = ex_q.rd;
    assign EX_RegWrite = ex_q.reg_write;
    assign EX_MemRead  = ex_q.mem_read;
    assign EX_MemWrite = ex_q.mem_write;
    assign EX_MemtoReg = ex_q.mem_to_reg;
    assign EX_ALUSrc   = ex_q.alu_src;
    assign EX_Branch   = ex_q.branch;
    assign EX_ALUOp    = ex_q.alu_op;
    assign EX_Funct    = ex_q.funct;
    assign EX_RD1      = ex_q.rd1;
    assign EX_RD2      = ex_q.rd2;
    assign EX_Imm      = ex_q.imm;
    assign EX_PC       = ex_q.pc;
    assign EX_Valid    = ex_q.valid;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Stall already excludes Hold and Flush, so it marks exactly the bubble-insert edges.
    assign stall_cnt_d = Stall ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
`else
    assign StallCount = 32'd0;
`endif

endmodule
